// File: rtl/boid_frame_writer_pkg.sv
// Shared boid/video parameters and the frame-writer FSM encoding, also used by the VGA
// controller and the display RAM.
package boid_frame_writer_pkg;

  localparam int unsigned VIDEO_WIDTH         = 640;
  localparam int unsigned VIDEO_HEIGHT        = 480;
  localparam int unsigned PIXEL_COUNT         = VIDEO_WIDTH * VIDEO_HEIGHT;
  localparam int unsigned PIXEL_ADDRESS_WIDTH = 19;
  localparam int unsigned MAX_BOIDS           = 4;
  localparam int unsigned BITS_FOR_BOIDS      = $clog2(MAX_BOIDS);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StScan,
    StDrain,
    StDone
  } fw_state_e;

endpackage

// File: rtl/boid_frame_writer_pixel_addr_calc.sv
// Combinational pixel address (x + 640*y) and on-screen flag; shared with the VGA read side.
module boid_frame_writer_pixel_addr_calc #(
  parameter int unsigned Width     = boid_frame_writer_pkg::VIDEO_WIDTH,
  parameter int unsigned Height    = boid_frame_writer_pkg::VIDEO_HEIGHT,
  parameter int unsigned AddrWidth = boid_frame_writer_pkg::PIXEL_ADDRESS_WIDTH
) (
  input  logic [9:0]           x_i,
  input  logic [8:0]           y_i,
  output logic [AddrWidth-1:0] addr_o,
  output logic                 in_range_o
);

  always_comb begin
    // 640*y as (y<<9)+(y<<7); the widest result (1023 + 511*640) still fits in 19 bits.
    addr_o     = AddrWidth'(x_i) + (AddrWidth'(y_i) << 9) + (AddrWidth'(y_i) << 7);
    in_range_o = (32'(x_i) < Width) && (32'(y_i) < Height);
  end

endmodule

// File: rtl/boid_frame_writer.sv
// Per-frame sequencer: clears the display RAM on end-of-frame, then writes one pixel per
// on-screen boid at one boid per cycle.
module boid_frame_writer #(
  parameter int unsigned MAX_BOIDS           = boid_frame_writer_pkg::MAX_BOIDS,
  parameter int unsigned BITS_FOR_BOIDS      = $clog2(MAX_BOIDS),
  parameter int unsigned VIDEO_WIDTH         = boid_frame_writer_pkg::VIDEO_WIDTH,
  parameter int unsigned VIDEO_HEIGHT        = boid_frame_writer_pkg::VIDEO_HEIGHT,
  parameter int unsigned PIXEL_ADDRESS_WIDTH = boid_frame_writer_pkg::PIXEL_ADDRESS_WIDTH
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           screen_end,
  output logic [BITS_FOR_BOIDS-1:0]      boid_index,
  input  logic [9:0]                     x_loc,
  input  logic [8:0]                     y_loc,
  output logic                           ram_clear,
  output logic                           ram_we,
  output logic [PIXEL_ADDRESS_WIDTH-1:0] ram_waddr,
  output logic                           busy,
  output logic                           frame_done,
  output logic [7:0]                     skipped_count,
  output logic                           overrun
);
  import boid_frame_writer_pkg::*;

  localparam logic [BITS_FOR_BOIDS-1:0] LastIndex = BITS_FOR_BOIDS'(MAX_BOIDS - 1);

  fw_state_e                      state_q, state_d;
  logic [BITS_FOR_BOIDS-1:0]      index_q, index_d;
  logic                           we_q, we_d;
  logic [PIXEL_ADDRESS_WIDTH-1:0] waddr_q, waddr_d;
  logic [7:0]                     skipped_q, skipped_d;
  logic                           overrun_q, overrun_d;

  logic [PIXEL_ADDRESS_WIDTH-1:0] calc_addr;
  logic                           calc_in_range;

  boid_frame_writer_pixel_addr_calc #(
    .Width    (VIDEO_WIDTH),
    .Height   (VIDEO_HEIGHT),
    .AddrWidth(PIXEL_ADDRESS_WIDTH)
  ) u_addr_calc (
    .x_i       (x_loc),
    .y_i       (y_loc),
    .addr_o    (calc_addr),
    .in_range_o(calc_in_range)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      index_q   <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      skipped_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      skipped_q <= skipped_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (screen_end) state_d = StClear;
      StClear: state_d = StScan;
      StScan:  if (index_q == LastIndex) state_d = StDrain;
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    index_d   = index_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    skipped_d = skipped_q;
    overrun_d = overrun_q | (screen_end && (state_q != StIdle));
    // Zero on entry so the count already reads 0 during the clear cycle.
    if (state_q == StIdle && screen_end) skipped_d = '0;
    if (state_q == StClear) index_d = '0;
    if (state_q == StScan) begin
      if (index_q != LastIndex) index_d = index_q + BITS_FOR_BOIDS'(1);
      if (calc_in_range) begin
        we_d    = 1'b1;
        waddr_d = calc_addr;
      end else if (skipped_q != 8'hff) begin
        skipped_d = skipped_q + 8'd1;
      end
    end
  end

  always_comb begin
    ram_clear     = (state_q == StClear);
    busy          = (state_q == StClear) || (state_q == StScan) || (state_q == StDrain);
    frame_done    = (state_q == StDone);
    boid_index    = index_q;
    ram_we        = we_q;
    ram_waddr     = waddr_q;
    skipped_count = skipped_q;
    overrun       = overrun_q;
  end

endmodule

// File: tb/tb_boid_frame_writer.sv
// Randomized bench for boid_frame_writer against a cycle-offset schedule model.
module tb_boid_frame_writer;

  localparam int M  = 4;
  localparam int M2 = 512;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        screen_end = 1'b0;
  logic        screen_end2 = 1'b0;

  logic [1:0]  boid_index;
  logic [9:0]  x_loc;
  logic [8:0]  y_loc;
  logic        ram_clear, ram_we, busy, frame_done, overrun;
  logic [18:0] ram_waddr;
  logic [7:0]  skipped_count;

  logic [8:0]  boid_index2;
  logic [9:0]  x_loc2;
  logic [8:0]  y_loc2;
  logic        ram_clear2, ram_we2, busy2, frame_done2, overrun2;
  logic [18:0] ram_waddr2;
  logic [7:0]  skipped_count2;

  logic [9:0]  bx [M];
  logic [8:0]  by [M];

  always #10 clock = ~clock;

  always_comb begin
    x_loc  = bx[boid_index];
    y_loc  = by[boid_index];
    x_loc2 = 10'd700 + {3'b000, boid_index2[8:2]};
    y_loc2 = boid_index2;
  end

  boid_frame_writer #(.MAX_BOIDS(M)) dut (
    .clock        (clock),
    .reset        (reset),
    .screen_end   (screen_end),
    .boid_index   (boid_index),
    .x_loc        (x_loc),
    .y_loc        (y_loc),
    .ram_clear    (ram_clear),
    .ram_we       (ram_we),
    .ram_waddr    (ram_waddr),
    .busy         (busy),
    .frame_done   (frame_done),
    .skipped_count(skipped_count),
    .overrun      (overrun)
  );

  boid_frame_writer #(.MAX_BOIDS(M2)) dut_sat (
    .clock        (clock),
    .reset        (reset),
    .screen_end   (screen_end2),
    .boid_index   (boid_index2),
    .x_loc        (x_loc2),
    .y_loc        (y_loc2),
    .ram_clear    (ram_clear2),
    .ram_we       (ram_we2),
    .ram_waddr    (ram_waddr2),
    .busy         (busy2),
    .frame_done   (frame_done2),
    .skipped_count(skipped_count2),
    .overrun      (overrun2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model: edge count n, acceptance edge a, offset d = n - a of the current cycle.
  int n = 0;
  int a = 0;
  int d = 0;
  bit active = 0;
  bit m_ovr = 0;
  bit m_we = 0;
  int m_waddr = 0;
  int m_skip = 0;

  task automatic model_reset();
    active  = 0;
    m_ovr   = 0;
    m_we    = 0;
    m_waddr = 0;
    m_skip  = 0;
  endtask

  task automatic model_edge(input bit se);
    int k;
    n++;
    if (se) begin
      if (active && (n - a) <= M + 3) m_ovr = 1;
      else begin
        active = 1;
        a      = n;
      end
    end
    m_we = 0;
    if (active) begin
      d = n - a;
      if (d == 0) m_skip = 0;
      if (d >= 2 && d <= M + 1) begin
        k = d - 2;
        if (int'(bx[k]) < 640 && int'(by[k]) < 480) begin
          m_we    = 1;
          m_waddr = int'(bx[k]) + 640 * int'(by[k]);
        end else if (m_skip < 255) begin
          m_skip++;
        end
      end
    end
  endtask

  task automatic compare();
    bit f;
    f = active && (d <= M + 2);
    check("ram_clear", ram_clear, f && d == 0);
    check("busy", busy, f && d <= M + 1);
    check("frame_done", frame_done, f && d == M + 2);
    check("ram_we", ram_we, m_we);
    check("ram_waddr", ram_waddr, m_waddr);
    check("skipped_count", skipped_count, m_skip);
    check("overrun", overrun, m_ovr);
    if (f && d >= 1 && d <= M) check("boid_index", boid_index, d - 1);
  endtask

  task automatic compare_reset();
    check("rst_boid_index", boid_index, 0);
    compare();
  endtask

  // Drive screen_end for one edge, then sample at the following falling edge.
  task automatic cycle(input bit se);
    screen_end = se;
    @(posedge clock);
    model_edge(se);
    @(negedge clock);
    compare();
  endtask

  task automatic idle(input int cnt);
    for (int i = 0; i < cnt; i++) cycle(1'b0);
  endtask

  task automatic set_pos(input int k, input int x, input int y);
    bx[k] = 10'(x);
    by[k] = 9'(y);
  endtask

  task automatic mid_reset();
    #3 reset = 1'b0;
    #1;
    model_reset();
    compare_reset();
    repeat (2) begin
      @(negedge clock);
      compare_reset();
    end
    reset = 1'b1;
  endtask

  initial begin
    int we_cnt;
    int clr_cnt;
    bit got;
    for (int k = 0; k < M; k++) set_pos(k, 0, 0);
    repeat (2) @(negedge clock);
    model_reset();
    compare_reset();
    reset = 1'b1;
    idle(2);

    // Basic writes
    set_pos(0, 0, 0); set_pos(1, 639, 479); set_pos(2, 100, 10); set_pos(3, 5, 1);
    cycle(1'b1);
    idle(8);
    check("basic_last_addr", ram_waddr, 645);

    // Off-screen boids
    set_pos(0, 640, 5); set_pos(1, 10, 480); set_pos(2, 1023, 511); set_pos(3, 3, 2);
    cycle(1'b1);
    idle(8);
    check("offscreen_skipped", skipped_count, 3);
    check("offscreen_addr", ram_waddr, 1283);

    // Back-to-back frames
    set_pos(0, 7, 7); set_pos(1, 700, 1); set_pos(2, 1, 470); set_pos(3, 600, 479);
    cycle(1'b1);
    idle(7);
    cycle(1'b1);
    idle(8);

    // Overrun: extra pulse mid-frame, then a clean frame at the first legal edge
    cycle(1'b1);
    idle(2);
    cycle(1'b1);
    idle(4);
    cycle(1'b1);
    idle(8);
    check("overrun_sticky", overrun, 1);

    // Reset mid-frame
    cycle(1'b1);
    idle(3);
    mid_reset();
    idle(3);
    cycle(1'b1);
    idle(8);

    // Randomized frames with stray screen_end pulses
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < M; k++) begin
        set_pos(k,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(640, 1023))
                                            : int'($urandom_range(0, 639)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(480, 511))
                                            : int'($urandom_range(0, 479)));
      end
      cycle(1'b1);
      for (int j = 0; j < M + 3 + int'($urandom_range(0, 3)); j++) begin
        cycle($urandom_range(0, 9) == 0);
      end
      idle(M + 4);
    end

    // Saturation on a 512-slot instance, all slots off-screen
    we_cnt  = 0;
    clr_cnt = 0;
    got     = 0;
    screen_end2 = 1'b1;
    @(negedge clock);
    screen_end2 = 1'b0;
    for (int i = 0; i < 700 && !got; i++) begin
      if (ram_we2) we_cnt++;
      if (ram_clear2) clr_cnt++;
      if (frame_done2) got = 1;
      else @(negedge clock);
    end
    check("sat_frame_done", got, 1);
    check("sat_ram_we", we_cnt, 0);
    check("sat_ram_clear", clr_cnt, 1);
    check("sat_skipped", skipped_count2, 255);
    check("sat_waddr", ram_waddr2, 0);
    check("sat_overrun", overrun2, 0);
    @(negedge clock);
    check("sat_busy", busy2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
